// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounced front-panel sequencer and MM:SS display path for the stopwatch.
// Define STOPWATCH_LAP_EN to build the LAP state and the frozen-display snapshot.
module stopwatch_ctrl #(
    parameter logic [15:0] DEB_CYCLES = 16'd50000,
    parameter int          DEB_W      = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_ss,
    input  logic       btn_lap,
    input  logic [3:0] sec_ones,
    input  logic [3:0] sec_tens,
    input  logic [3:0] min_ones,
    input  logic [3:0] min_tens,
    output logic       start_stop,
    output logic       clr,
    output logic       running,
    output logic       lap_active,
    output logic [3:0] disp_sec_ones,
    output logic [3:0] disp_sec_tens,
    output logic [3:0] disp_min_ones,
    output logic [3:0] disp_min_tens
);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 16'd1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_LAP, ST_PAUSED} state_t;

    logic [1:0]  btn_raw;
    logic [1:0]  press;
    logic [15:0] live;

    assign btn_raw = {btn_lap, btn_ss};
    assign live    = {min_tens, min_ones, sec_tens, sec_ones};

    // Index 0 is start/stop, index 1 is lap/clear.
    for (genvar gi = 0; gi < 2; gi++) begin : g_deb
        logic             sync1_reg;
        logic             sync2_reg;
        logic             level_reg;
        logic             press_reg;
        logic [DEB_W-1:0] cnt_reg;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync1_reg <= 1'b0;
                sync2_reg <= 1'b0;
                level_reg <= 1'b0;
                press_reg <= 1'b0;
                cnt_reg   <= '0;
            end else begin
                sync1_reg <= btn_raw[gi];
                sync2_reg <= sync1_reg;
                press_reg <= 1'b0;
                if (sync2_reg != level_reg) begin
                    if (cnt_reg == DEB_LAST) begin
                        cnt_reg   <= '0;
                        level_reg <= sync2_reg;
                        press_reg <= sync2_reg;
                    end else begin
                        cnt_reg <= cnt_reg + DEB_W'(1);
                    end
                end else begin
                    cnt_reg <= '0;
                end
            end
        end

        assign press[gi] = press_reg;
    end

    logic   ss_ev;
    logic   lap_ev;
    state_t state_reg;
    state_t state_next;
    logic   start_stop_reg;
    logic   start_stop_next;
    logic   clr_reg;
    logic   clr_next;
`ifdef STOPWATCH_LAP_EN
    logic   capture;
`endif

    // A start/stop event wins over a lap event arriving in the same cycle.
    assign ss_ev  = press[0];
    assign lap_ev = press[1] & ~press[0];

    always_comb begin
        state_next      = state_reg;
        start_stop_next = 1'b0;
        clr_next        = 1'b0;
`ifdef STOPWATCH_LAP_EN
        capture         = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (ss_ev) begin
                    state_next      = ST_RUN;
                    start_stop_next = 1'b1;
                end
            end
            ST_RUN: begin
                if (ss_ev) begin
                    state_next      = ST_PAUSED;
                    start_stop_next = 1'b1;
                end
`ifdef STOPWATCH_LAP_EN
                else if (lap_ev) begin
                    state_next = ST_LAP;
                    capture    = 1'b1;
                end
`endif
            end
`ifdef STOPWATCH_LAP_EN
            ST_LAP: begin
                if (ss_ev) begin
                    state_next      = ST_PAUSED;
                    start_stop_next = 1'b1;
                end else if (lap_ev) begin
                    state_next = ST_RUN;
                end
            end
`endif
            ST_PAUSED: begin
                if (ss_ev) begin
                    state_next      = ST_RUN;
                    start_stop_next = 1'b1;
                end else if (lap_ev) begin
                    state_next = ST_IDLE;
                    clr_next   = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            start_stop_reg <= 1'b0;
            clr_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            start_stop_reg <= start_stop_next;
            clr_reg        <= clr_next;
        end
    end

    assign start_stop = start_stop_reg;
    assign clr        = clr_reg;
    assign running    = (state_reg == ST_RUN) || (state_reg == ST_LAP);

`ifdef STOPWATCH_LAP_EN
    logic [15:0] snap_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_reg <= '0;
        end else if (capture) begin
            snap_reg <= live;
        end
    end

    assign lap_active = (state_reg == ST_LAP);
    assign {disp_min_tens, disp_min_ones, disp_sec_tens, disp_sec_ones} =
        lap_active ? snap_reg : live;
`else
    assign lap_active = 1'b0;
    assign {disp_min_tens, disp_min_ones, disp_sec_tens, disp_sec_ones} = live;
`endif

endmodule
